kuart_inject_sched: RTL

Schedules kernel-console command injection for cosim. Multiple requesters (test harness, end-of-run trigger, watchdog) each ask to inject one command byte into the kernel UART RX path. The block arbitrates round-robin, drives the byte with a valid/ready handshake, then holds the channel until the kernel echoes a terminator byte or a timeout expires. It sits between the harness requesters and the kernel UART inject/monitor taps.

---
 rtl/kuart_cosim_pkg.sv | 16 +
 rtl/kuart_inject_sched_rr_arbiter.sv | 32 +++
 rtl/kuart_inject_sched.sv | 120 ++++++++++++
 3 files changed

// File: rtl/kuart_cosim_pkg.sv
// Purpose: shared types and constants for the kernel-console inject scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package kuart_cosim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_TERM = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam logic [7:0] CHAR_DOT = 8'h2E;  // '.' command terminator
  localparam logic [7:0] CHAR_R   = 8'h72;  // 'r' typical harness command

endpackage

// File: rtl/kuart_inject_sched_rr_arbiter.sv
// Purpose: round-robin pick of the first set request at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is taken.
// Ports: req (request levels), ptr (search start), grant_valid, grant_idx.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            grant_valid,
  output logic [IW-1:0]   grant_idx
);

  int idx;

  // Scan offsets from farthest to nearest so the nearest hit overwrites
  // any farther one, avoiding a loop break.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/kuart_inject_sched.sv
// Purpose: round-robin injection of one command byte into the kernel UART RX path, then wait for a terminator echo or timeout.
// Latency: grant 1 cycle after req; ack pulses 1 cycle after terminator seen or after TIMEOUT_CYCLES cycles in WAIT_TERM.
// Backpressure: kuart_to_cpu_valid and byte held stable until kuart_to_cpu_ready; requesters hold req until ack.
// Ports: req/req_char (requesters), ack (one-hot done pulse), busy, kuart_to_cpu* (inject tap),
//        kuart_from_cpu* (monitor tap), cmd_ok/cmd_timeout (completion status pulses), last_id.
module kuart_inject_sched
  import kuart_cosim_pkg::*;
#(
  parameter int         NREQ           = 2,
  parameter logic [7:0] TERM_CHAR      = CHAR_DOT,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_char,
  output logic [NREQ-1:0]   ack,
  output logic              busy,
  output logic [7:0]        kuart_to_cpu,
  output logic              kuart_to_cpu_valid,
  input  logic              kuart_to_cpu_ready,
  input  logic [7:0]        kuart_from_cpu,
  input  logic              kuart_from_cpu_valid,
  output logic              cmd_ok,
  output logic              cmd_timeout,
  output logic [2:0]        last_id
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t        state_q, state_d;
  logic [IW-1:0] id_q;
  logic [IW-1:0] rr_ptr_q;
  logic [7:0]    byte_q;
  logic [CW-1:0] cnt_q;
  logic          ok_q;
  logic [2:0]    last_id_q;

  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  logic          term_hit;
  logic          tmo_hit;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req         (req),
    .ptr         (rr_ptr_q),
    .grant_valid (gnt_vld),
    .grant_idx   (gnt_idx)
  );

  assign term_hit = kuart_from_cpu_valid && (kuart_from_cpu == TERM_CHAR);
  assign tmo_hit  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Outputs decode from state only, so an async reset drops them at once.
  always_comb begin
    state_d            = state_q;
    busy               = (state_q != ST_IDLE);
    kuart_to_cpu_valid = 1'b0;
    kuart_to_cpu       = 8'h00;
    ack                = '0;
    cmd_ok             = 1'b0;
    cmd_timeout        = 1'b0;
    case (state_q)
      ST_IDLE: if (gnt_vld) state_d = ST_SEND;
      ST_SEND: begin
        kuart_to_cpu_valid = 1'b1;
        kuart_to_cpu       = byte_q;
        if (kuart_to_cpu_ready) state_d = ST_WAIT_TERM;
      end
      ST_WAIT_TERM: if (term_hit || tmo_hit) state_d = ST_DONE;
      ST_DONE: begin
        ack[id_q]   = 1'b1;
        cmd_ok      = ok_q;
        cmd_timeout = !ok_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q      <= '0;
      rr_ptr_q  <= '0;
      byte_q    <= 8'h00;
      cnt_q     <= '0;
      ok_q      <= 1'b0;
      last_id_q <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            id_q   <= gnt_idx;
            byte_q <= req_char[8*int'(gnt_idx) +: 8];
          end
        end
        ST_SEND: if (kuart_to_cpu_ready) cnt_q <= '0;
        ST_WAIT_TERM: begin
          cnt_q <= cnt_q + CW'(1);
          // Terminator beats a coinciding timeout.
          if (term_hit || tmo_hit) begin
            ok_q      <= term_hit;
            last_id_q <= 3'(id_q);
          end
        end
        ST_DONE: rr_ptr_q <= (id_q == IW'(NREQ - 1)) ? '0 : id_q + IW'(1);
        default: ;
      endcase
    end
  end

  assign last_id = last_id_q;

endmodule
